// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: word width, stage
// numbering and the memory-stage state encoding.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] STAGE_IF  = 3'd0;
    localparam logic [2:0] STAGE_ID  = 3'd1;
    localparam logic [2:0] STAGE_EX  = 3'd2;
    localparam logic [2:0] STAGE_MEM = 3'd3;
    localparam logic [2:0] STAGE_WB  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_stage.sv
// MEM stage of the multi-cycle MIPS datapath: runs one data-memory access over
// a req/ack handshake and produces the registered write-back word for stage 4.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int         TIMEOUT   = 16,
    parameter logic [2:0] MEM_STAGE = STAGE_MEM
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [2:0]        stage,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic [WORD_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [WORD_W-1:0] wb_data,
    output logic              wb_valid,
    output logic              stall,
    output logic              mem_err
);

    localparam int            CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              m2r_q, m2r_d;
    logic [WORD_W-1:0] wb_data_q, wb_data_d;
    logic              wb_valid_q, wb_valid_d;
    logic              stall_q, stall_d;
    logic              err_q, err_d;

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        m2r_d     = m2r_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (stage == MEM_STAGE) begin
                    err_d = 1'b0;
                    if (mem_read && mem_write) begin
                        err_d     = 1'b1;
                        wb_data_d = {WORD_W{1'b0}};
                        state_d   = ST_DONE;
                    end else if ((mem_read || mem_write) && !is_word_aligned(alu_result)) begin
                        err_d     = 1'b1;
                        wb_data_d = {WORD_W{1'b0}};
                        state_d   = ST_DONE;
                    end else if (mem_read || mem_write) begin
                        addr_d  = alu_result;
                        wdata_d = store_data;
                        we_d    = mem_write;
                        m2r_d   = mem_to_reg;
                        req_d   = 1'b1;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_REQ;
                    end else begin
                        wb_data_d = alu_result;
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // The latched address doubles as the non-load result, so inputs may move freely here.
                if (dmem_ack) begin
                    req_d     = 1'b0;
                    wb_data_d = m2r_q ? (we_q ? {WORD_W{1'b0}} : dmem_rdata) : addr_q;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    wb_data_d = {WORD_W{1'b0}};
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        wb_valid_d = (state_d == ST_DONE);
        stall_d    = (state_d == ST_REQ);
    end

    // State and registered outputs; reset drops any outstanding request at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {WORD_W{1'b0}};
            wdata_q    <= {WORD_W{1'b0}};
            m2r_q      <= 1'b0;
            wb_data_q  <= {WORD_W{1'b0}};
            wb_valid_q <= 1'b0;
            stall_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m2r_q      <= m2r_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_data    = wb_data_q;
    assign wb_valid   = wb_valid_q;
    assign stall      = stall_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, randomized
// transactions against a transaction-level model, and a reset-during-request sequence.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  stage;
    logic [31:0] alu_result, store_data, dmem_rdata;
    logic        mem_read, mem_write, mem_to_reg, dmem_ack;
    logic        dmem_req, dmem_we, wb_valid, stall, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] last_wb;
    logic        last_err;

    mem_access_stage dut (
        .clock(clock), .reset_n(reset_n), .stage(stage),
        .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_data(wb_data), .wb_valid(wb_valid), .stall(stall), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic        rd;
        logic        wr;
        logic        m2r;
        int          delay;   // REQ cycle index at which ack is offered
        logic [31:0] rdata;
        int          exp_cyc; // number of stall cycles
        logic [31:0] exp_wb;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: outcome of one access from the operation's rules only.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.rd && v.wr) begin
            r.exp_cyc = 0; r.exp_wb = 32'd0; r.exp_err = 1'b1;
        end else if ((v.rd || v.wr) && (v.alu % 4 != 0)) begin
            r.exp_cyc = 0; r.exp_wb = 32'd0; r.exp_err = 1'b1;
        end else if (v.rd || v.wr) begin
            if (v.delay < 16) begin
                r.exp_cyc = v.delay + 1;
                r.exp_err = 1'b0;
                r.exp_wb  = !v.m2r ? v.alu : (v.wr ? 32'd0 : v.rdata);
            end else begin
                r.exp_cyc = 16; r.exp_err = 1'b1; r.exp_wb = 32'd0;
            end
        end else begin
            r.exp_cyc = 0; r.exp_wb = v.alu; r.exp_err = 1'b0;
        end
        return r;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        stage = 3'd3; alu_result = v.alu; store_data = v.sd;
        mem_read = v.rd; mem_write = v.wr; mem_to_reg = v.m2r; dmem_ack = 1'b0;
        tick();
        cyc = 0;
        while (stall && cyc < 40) begin
            stage      = 3'($urandom_range(0, 4));
            alu_result = $urandom;
            store_data = $urandom;
            chk({tag, " req"}, {31'd0, dmem_req}, 32'd1);
            chk({tag, " addr"}, dmem_addr, v.alu);
            chk({tag, " we"}, {31'd0, dmem_we}, {31'd0, v.wr});
            if (v.wr) chk({tag, " wdata"}, dmem_wdata, v.sd);
            dmem_ack   = (cyc == v.delay);
            dmem_rdata = (cyc == v.delay) ? v.rdata : $urandom;
            tick();
            dmem_ack = 1'b0;
            cyc++;
        end
        stage = 3'd0;
        chk({tag, " stall_cycles"}, cyc, v.exp_cyc);
        chk({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, " wb_data"}, wb_data, v.exp_wb);
        chk({tag, " mem_err"}, {31'd0, mem_err}, {31'd0, v.exp_err});
        chk({tag, " req_low"}, {31'd0, dmem_req}, 32'd0);
        last_wb  = v.exp_wb;
        last_err = v.exp_err;
        tick();
        chk({tag, " pulse_end"}, {31'd0, wb_valid}, 32'd0);
    endtask

    // Idle cycles with stage away from MEM: nothing may start, results hold, stray acks ignored.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            stage      = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd4;
            mem_read   = 1'($urandom);
            mem_write  = 1'($urandom);
            alu_result = $urandom;
            dmem_ack   = 1'($urandom);
            dmem_rdata = $urandom;
            tick();
            chk({tag, " idle_req"}, {31'd0, dmem_req}, 32'd0);
            chk({tag, " idle_valid"}, {31'd0, wb_valid}, 32'd0);
            chk({tag, " idle_wb_hold"}, wb_data, last_wb);
            chk({tag, " idle_err_hold"}, {31'd0, mem_err}, {31'd0, last_err});
        end
        dmem_ack = 1'b0;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        reset_n = 1'b0; stage = 3'd0; alu_result = 32'd0; store_data = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        last_wb = 32'd0; last_err = 1'b0;

        //         alu           sd           rd    wr    m2r   dly rdata          cyc wb            err
        tbl.push_back('{32'd55,      32'd0,      1'b0, 1'b0, 1'b0, 0,  32'd0,         0,  32'd55,       1'b0});
        tbl.push_back('{32'h40,      32'd0,      1'b1, 1'b0, 1'b1, 2,  32'hDEADBEEF,  3,  32'hDEADBEEF, 1'b0});
        tbl.push_back('{32'h10,      32'h1234,   1'b0, 1'b1, 1'b0, 0,  32'd0,         1,  32'h10,       1'b0});
        tbl.push_back('{32'h42,      32'd0,      1'b1, 1'b0, 1'b1, 0,  32'd0,         0,  32'd0,        1'b1});
        tbl.push_back('{32'h40,      32'h99,     1'b1, 1'b1, 1'b1, 0,  32'd0,         0,  32'd0,        1'b1});
        tbl.push_back('{32'h80,      32'd0,      1'b1, 1'b0, 1'b1, 30, 32'h5555AAAA,  16, 32'd0,        1'b1});
        tbl.push_back('{32'd7,       32'd0,      1'b0, 1'b0, 1'b1, 0,  32'd0,         0,  32'd7,        1'b0});
        tbl.push_back('{32'h100,     32'hCAFE,   1'b0, 1'b1, 1'b1, 5,  32'h77,        6,  32'd0,        1'b0});
        tbl.push_back('{32'h13,      32'h1,      1'b0, 1'b1, 1'b0, 0,  32'd0,         0,  32'd0,        1'b1});
        tbl.push_back('{32'h200,     32'd0,      1'b1, 1'b0, 1'b1, 15, 32'h0BADF00D,  16, 32'h0BADF00D, 1'b0});
        tbl.push_back('{32'h300,     32'd0,      1'b1, 1'b0, 1'b0, 1,  32'h12345678,  2,  32'h300,      1'b0});

        #23;
        chk("reset req", {31'd0, dmem_req}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset mem_err", {31'd0, mem_err}, 32'd0);
        chk("reset addr", dmem_addr, 32'd0);
        reset_n = 1'b1;
        idle(2, "post_reset");

        foreach (tbl[i]) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
            idle(2, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 60; n++) begin
            v.alu   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            v.sd    = $urandom;
            v.rd    = 1'($urandom);
            v.wr    = ($urandom_range(0, 5) == 0) ? v.rd : (v.rd ? 1'b0 : 1'($urandom));
            v.m2r   = 1'($urandom);
            v.delay = int'($urandom_range(0, 18));
            v.rdata = $urandom;
            v = model(v);
            run_op(v, $sformatf("rnd%0d", n));
            idle(int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
        end

        // Reset while a store request is outstanding.
        stage = 3'd3; alu_result = 32'h20; store_data = 32'hABCD;
        mem_read = 1'b0; mem_write = 1'b1; mem_to_reg = 1'b0; dmem_ack = 1'b0;
        tick();
        stage = 3'd0;
        tick();
        chk("rst_mid req_before", {31'd0, dmem_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mid stall", {31'd0, stall}, 32'd0);
        chk("rst_mid wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_mid mem_err", {31'd0, mem_err}, 32'd0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dmem_ack = 1'b1; dmem_rdata = $urandom;
            tick();
            chk("rst_mid no_valid", {31'd0, wb_valid}, 32'd0);
            chk("rst_mid no_req", {31'd0, dmem_req}, 32'd0);
            chk("rst_mid wb_zero", wb_data, 32'd0);
        end
        dmem_ack = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
